// File: rtl/keccak_squeeze_unit.sv
// rtl/keccak_squeeze_unit.sv - streams Keccak rate bytes out as keep-masked beats, requesting permutations between blocks
module keccak_squeeze_unit #(
   parameter int DWIDTH        = 256,
   parameter int KEEP_WIDTH    = 32,
   parameter int RATE_WIDTH    = 11,
   parameter int OUT_LEN_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_i,
   input  logic [RATE_WIDTH-1:0]         rate_i,
   input  logic [OUT_LEN_WIDTH-1:0]      out_len_i,
   input  logic [4:0][4:0][63:0]         state_array_i,
   input  logic                          permute_done_i,
   output logic                          permute_req_o,
   output logic [DWIDTH-1:0]             data_o,
   output logic [KEEP_WIDTH-1:0]         keep_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          last_o,
   output logic                          busy_o,
   output logic                          done_o
);

   // Number of bits needed to hold a beat byte count 0..KEEP_WIDTH.
   localparam int NW = $clog2(KEEP_WIDTH + 1);
   // Total bytes in the 1600-bit state.
   localparam int STATE_BYTES = 200;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SQUEEZE = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;

   logic [1:0]               fsm_q;
   logic [RATE_WIDTH-1:0]    rate_q;
   // Byte offset into the current block; rate/8 never exceeds 168 so RATE_WIDTH bits is ample.
   logic [RATE_WIDTH-1:0]    offset_q;
   logic [OUT_LEN_WIDTH-1:0] remaining_q;

   logic [1599:0]            state_flat;
   logic [RATE_WIDTH-1:0]    rate_bytes;
   logic [RATE_WIDTH-1:0]    offset_next;
   logic [OUT_LEN_WIDTH-1:0] remaining_next;
   logic [NW-1:0]            n_beat;
   int                       n_int;
   int                       avail;
   logic                     squeezing;
   logic                     accept;

   assign squeezing  = (fsm_q == S_SQUEEZE);
   assign valid_o    = squeezing;
   assign busy_o     = (fsm_q != S_IDLE);
   assign accept     = squeezing && ready_i;
   assign rate_bytes = rate_q >> 3;

   // Flatten the lane array into byte order: lane L lives at x=L%5, y=L/5, little-endian bytes.
   always_comb begin
      state_flat = '0;
      for (int l = 0; l < 25; l++) begin
         state_flat[64*l +: 64] = state_array_i[l % 5][l / 5];
      end
   end

   // Beat size: bounded by the beat width, what is left of this block, and what is left of the request.
   always_comb begin
      avail = int'(rate_bytes) - int'(offset_q);
      n_int = KEEP_WIDTH;
      if (avail < n_int) n_int = avail;
      if (int'(remaining_q) < n_int) n_int = int'(remaining_q);
      if (n_int < 0) n_int = 0;
      n_beat         = NW'(n_int);
      offset_next    = offset_q + RATE_WIDTH'(n_beat);
      remaining_next = remaining_q - OUT_LEN_WIDTH'(n_beat);
      last_o         = squeezing && (remaining_q == OUT_LEN_WIDTH'(n_beat));
   end

   // Select state bytes offset..offset+n-1 into the low lanes of the beat; everything else reads zero.
   always_comb begin
      int idx;
      idx    = 0;
      data_o = '0;
      keep_o = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         if (squeezing && (i < n_int)) begin
            keep_o[i] = 1'b1;
            idx       = int'(offset_q) + i;
            if (idx < STATE_BYTES) begin
               data_o[8*i +: 8] = state_flat[8*idx +: 8];
            end
         end
      end
   end

   // Control FSM: latch the request, advance per accepted beat, hand off to the engine at block ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q         <= S_IDLE;
         rate_q        <= '0;
         offset_q      <= '0;
         remaining_q   <= '0;
         permute_req_o <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         permute_req_o <= 1'b0;
         done_o        <= 1'b0;
         case (fsm_q)
            S_IDLE: begin
               if (start_i) begin
                  rate_q      <= rate_i;
                  remaining_q <= out_len_i;
                  offset_q    <= '0;
                  if (out_len_i == '0) begin
                     done_o <= 1'b1;
                  end else begin
                     fsm_q <= S_SQUEEZE;
                  end
               end
            end
            S_SQUEEZE: begin
               if (accept) begin
                  remaining_q <= remaining_next;
                  if (last_o) begin
                     fsm_q    <= S_IDLE;
                     offset_q <= '0;
                     done_o   <= 1'b1;
                  end else if (offset_next == rate_bytes) begin
                     fsm_q         <= S_WAIT;
                     offset_q      <= '0;
                     permute_req_o <= 1'b1;
                  end else begin
                     offset_q <= offset_next;
                  end
               end
            end
            S_WAIT: begin
               if (permute_done_i) begin
                  fsm_q <= S_SQUEEZE;
               end
            end
            default: fsm_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// tb/tb_keccak_squeeze_unit.sv - scoreboard bench for keccak_squeeze_unit
module tb_keccak_squeeze_unit;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start_i;
   logic [10:0]           rate_i;
   logic [15:0]           out_len_i;
   logic [4:0][4:0][63:0] st;
   logic                  permute_done_i;
   logic                  permute_req_o;
   logic [255:0]          data_o;
   logic [31:0]           keep_o;
   logic                  valid_o;
   logic                  ready_i;
   logic                  last_o;
   logic                  busy_o;
   logic                  done_o;

   keccak_squeeze_unit dut (
      .clk(clk), .rst(rst), .start_i(start_i), .rate_i(rate_i), .out_len_i(out_len_i),
      .state_array_i(st), .permute_done_i(permute_done_i), .permute_req_o(permute_req_o),
      .data_o(data_o), .keep_o(keep_o), .valid_o(valid_o), .ready_i(ready_i),
      .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
   } beat_t;

   beat_t exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   int preq_cnt = 0;
   int beat_cnt = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [255:0] lane_beat(input logic [7:0] base, input int first_lane, input int nbytes);
      logic [255:0] d = '0;
      for (int i = 0; i < nbytes; i++) d[8*i +: 8] = base + 8'(first_lane + i / 8);
      return d;
   endfunction

   function automatic logic [31:0] keep_of(input int n);
      logic [31:0] k = '0;
      for (int i = 0; i < n; i++) k[i] = 1'b1;
      return k;
   endfunction

   task automatic fill_pattern(input logic [7:0] base);
      for (int l = 0; l < 25; l++) st[l % 5][l / 5] = {8{8'(base + 8'(l))}};
   endtask

   task automatic push(input logic [255:0] d, input logic [31:0] k, input logic l);
      beat_t b;
      b.data = d; b.keep = k; b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic start_op(input int rate, input int len);
      @(posedge clk); #1;
      rate_i = 11'(rate); out_len_i = 16'(len); start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int base, input string name);
      int k = 0;
      while (done_cnt == base && k < 300) begin tick(1); k++; end
      check(name, done_cnt, base + 1);
      tick(1);
   endtask

   // Monitor: scoreboard pops on every accepted beat; stalled beats must hold still.
   logic         stall_prev = 1'b0;
   logic [255:0] held_d;
   logic [31:0]  held_k;
   logic         held_l;
   always @(negedge clk) begin
      beat_t e;
      if (done_o) done_cnt++;
      if (permute_req_o) preq_cnt++;
      if (valid_o && stall_prev) begin
         check("stall_data", data_o, held_d);
         check("stall_keep", 256'(keep_o), 256'(held_k));
         check("stall_last", 256'(last_o), 256'(held_l));
      end
      if (valid_o && ready_i) begin
         beat_cnt++;
         stall_prev = 1'b0;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got data %h keep %h, required no beat", data_o, keep_o);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", data_o, e.data);
            check("beat_keep", 256'(keep_o), 256'(e.keep));
            check("beat_last", 256'(last_o), 256'(e.last));
         end
      end else if (valid_o) begin
         stall_prev = 1'b1;
         held_d = data_o; held_k = keep_o; held_l = last_o;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int db, pb, bb, k;
      rst = 1'b1; start_i = 1'b0; rate_i = '0; out_len_i = '0;
      permute_done_i = 1'b0; ready_i = 1'b1; st = '0;
      #12;
      check("rst_valid", 256'(valid_o), 256'(0));
      check("rst_busy", 256'(busy_o), 256'(0));
      check("rst_done", 256'(done_o), 256'(0));
      check("rst_preq", 256'(permute_req_o), 256'(0));
      check("rst_keep", 256'(keep_o), 256'(0));
      check("rst_data", data_o, 256'(0));
      @(posedge clk); #1 rst = 1'b0;

      // 1: SHA3-256 single beat
      st = '0;
      for (int l = 0; l < 4; l++) st[l % 5][l / 5] = 64'h1111_2222_3333_4444;
      push({4{64'h1111_2222_3333_4444}}, 32'hFFFF_FFFF, 1'b1);
      db = done_cnt; pb = preq_cnt;
      start_op(1088, 32);
      wait_done(db, "c1_done");
      check("c1_no_preq", preq_cnt, pb);

      // 2: SHA3-512 two beats
      fill_pattern(8'h10);
      push(lane_beat(8'h10, 0, 32), 32'hFFFF_FFFF, 1'b0);
      push(lane_beat(8'h10, 4, 32), 32'hFFFF_FFFF, 1'b1);
      db = done_cnt;
      start_op(576, 64);
      wait_done(db, "c2_done");

      // 3: SHAKE256 across a permutation
      fill_pattern(8'h20);
      push(lane_beat(8'h20, 0, 32), 32'hFFFF_FFFF, 1'b0);
      push(lane_beat(8'h20, 4, 32), 32'hFFFF_FFFF, 1'b0);
      push(lane_beat(8'h20, 8, 32), 32'hFFFF_FFFF, 1'b0);
      push(lane_beat(8'h20, 12, 32), 32'hFFFF_FFFF, 1'b0);
      push(lane_beat(8'h20, 16, 8), 32'h0000_00FF, 1'b0);
      push(lane_beat(8'h60, 0, 32), 32'hFFFF_FFFF, 1'b0);
      push(lane_beat(8'h60, 4, 32), 32'hFFFF_FFFF, 1'b1);
      db = done_cnt; pb = preq_cnt;
      start_op(1088, 200);
      k = 0;
      while (preq_cnt == pb && k < 100) begin tick(1); k++; end
      check("c3_preq_seen", preq_cnt, pb + 1);
      check("c3_beats_before_perm", beat_cnt >= 5, 1);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("c3_wait_valid", 256'(valid_o), 256'(0));
         check("c3_wait_busy", 256'(busy_o), 256'(1));
      end
      fill_pattern(8'h60);
      permute_done_i = 1'b1; tick(1); permute_done_i = 1'b0;
      wait_done(db, "c3_done");
      check("c3_one_preq", preq_cnt, pb + 1);

      // 4: partial beat, upper bytes zero even though neighbouring lanes are not
      st = '0;
      st[0][0] = 64'h0000_00AA_BBCC_DDEE;
      for (int l = 1; l < 4; l++) st[l % 5][l / 5] = '1;
      push({216'h0, 40'hAABB_CCDD_EE}, 32'h0000_001F, 1'b1);
      db = done_cnt;
      start_op(1344, 5);
      wait_done(db, "c4_done");

      // 5: backpressure on the first beat of case 2
      fill_pattern(8'h10);
      push(lane_beat(8'h10, 0, 32), 32'hFFFF_FFFF, 1'b0);
      push(lane_beat(8'h10, 4, 32), 32'hFFFF_FFFF, 1'b1);
      db = done_cnt; bb = beat_cnt;
      ready_i = 1'b0;
      start_op(576, 64);
      tick(3);
      check("c5_stall_valid", 256'(valid_o), 256'(1));
      check("c5_stall_keep", 256'(keep_o), 256'(32'hFFFF_FFFF));
      check("c5_no_accept", beat_cnt, bb);
      ready_i = 1'b1;
      wait_done(db, "c5_done");
      check("c5_two_beats", beat_cnt, bb + 2);

      // 6a: zero-length request
      db = done_cnt; bb = beat_cnt; pb = preq_cnt;
      start_op(1088, 0);
      wait_done(db, "c6a_done");
      check("c6a_no_beats", beat_cnt, bb);
      check("c6a_idle", 256'(busy_o), 256'(0));
      check("c6a_no_preq", preq_cnt, pb);

      // 6b: start_i while busy and stray permute_done_i in SQUEEZE are ignored
      st = '0;
      st[0][0] = 64'h0000_00AA_BBCC_DDEE;
      for (int l = 1; l < 4; l++) st[l % 5][l / 5] = '1;
      push({216'h0, 40'hAABB_CCDD_EE}, 32'h0000_001F, 1'b1);
      db = done_cnt; pb = preq_cnt;
      ready_i = 1'b0;
      start_op(1344, 5);
      rate_i = 11'd576; out_len_i = 16'd0; start_i = 1'b1; permute_done_i = 1'b1;
      tick(1);
      start_i = 1'b0; permute_done_i = 1'b0;
      tick(1);
      check("c6b_busy", 256'(busy_o), 256'(1));
      check("c6b_valid", 256'(valid_o), 256'(1));
      check("c6b_keep", 256'(keep_o), 256'(32'h1F));
      ready_i = 1'b1;
      wait_done(db, "c6b_done");
      tick(3);
      check("c6b_single_done", done_cnt, db + 1);
      check("c6b_no_preq", preq_cnt, pb);

      // 6c: asynchronous reset mid-request
      fill_pattern(8'h20);
      db = done_cnt; bb = beat_cnt;
      ready_i = 1'b0;
      start_op(1088, 200);
      tick(2);
      check("c6c_pre_valid", 256'(valid_o), 256'(1));
      #2 rst = 1'b1;
      #1;
      check("c6c_rst_busy", 256'(busy_o), 256'(0));
      check("c6c_rst_valid", 256'(valid_o), 256'(0));
      check("c6c_rst_keep", 256'(keep_o), 256'(0));
      @(posedge clk); #1 rst = 1'b0;
      ready_i = 1'b1;
      tick(5);
      check("c6c_no_done", done_cnt, db);
      check("c6c_no_beats", beat_cnt, bb);
      check("c6c_idle", 256'(busy_o), 256'(0));
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
